// File: rtl/i281_pkg.sv
// i281_pkg
// Shared definitions for the i281 front end: default address and instruction
// widths, the PC value loaded by reset, and the fetch sequencer state type.
package i281_pkg;

  localparam int PC_WIDTH    = 6;
  localparam int INSTR_WIDTH = 16;

  // Program starts at address 0 after reset.
  localparam int unsigned RESET_PC = 0;

  // One instruction cycle walks FETCH -> WAIT -> EXEC. HALTED is terminal
  // until reset.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    WAIT   = 3'd2,
    EXEC   = 3'd3,
    HALTED = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch_sequencer_step_edge_detect.sv
// step_edge_detect
// Rising-edge detector for the debounced front-panel step button.
// Ports:
//   clk       system clock
//   reset     synchronous active-high reset, clears the history register
//   step      debounced button level
//   step_rise one-cycle pulse while step is high and was low last cycle
module step_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic step,
  output logic step_rise
);

  logic step_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step;
    end
  end

  assign step_rise = step & ~step_q;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer
// Holds the i281 program counter and sequences instruction fetch through
// FETCH -> WAIT -> EXEC, with free-run, single-step and halt for the panel.
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   run               level, fetch continuously while high
//   step              debounced button, each rising edge runs one instruction
//   halt_req          from decoder, honoured only in EXEC
//   next_pc_address   PC for the next instruction from the PC update logic
//   imem_rdata        instruction memory data, one cycle after imem_en
//   current_pc        PC register (also drives the PC update logic/display)
//   imem_addr         instruction memory address, equal to current_pc
//   imem_en           instruction memory read enable (registered)
//   instr             instruction register
//   instr_valid       one-cycle commit qualifier per instruction (registered)
//   halted            sequencer is in HALTED (registered)
//   retired_count     completed instructions, saturating
module pc_fetch_sequencer
  import i281_pkg::*;
#(
  parameter int PC_WIDTH    = i281_pkg::PC_WIDTH,
  parameter int INSTR_WIDTH = i281_pkg::INSTR_WIDTH,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic                   step,
  input  logic                   halt_req,
  input  logic [PC_WIDTH-1:0]    next_pc_address,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [PC_WIDTH-1:0]    current_pc,
  output logic [PC_WIDTH-1:0]    imem_addr,
  output logic                   imem_en,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic                   instr_valid,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] retired_count
);

  fetch_state_t state;
  logic         step_rise;

  // Counter sticks at all-ones instead of wrapping.
  function automatic logic [COUNT_WIDTH-1:0] sat_inc(
    input logic [COUNT_WIDTH-1:0] v
  );
    return (&v) ? v : v + COUNT_WIDTH'(1);
  endfunction

  step_edge_detect u_step_edge (
    .clk       (clk),
    .reset     (reset),
    .step      (step),
    .step_rise (step_rise)
  );

  // The PC only moves on the EXEC edge, so the address is just the PC.
  assign imem_addr = current_pc;

  // Outputs are registered alongside the state: each is set on the edge that
  // enters the state in which it must be visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      current_pc    <= PC_WIDTH'(RESET_PC);
      instr         <= '0;
      instr_valid   <= 1'b0;
      imem_en       <= 1'b0;
      halted        <= 1'b0;
      retired_count <= '0;
    end else begin
      imem_en     <= 1'b0;
      instr_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (run || step_rise) begin
            state   <= FETCH;
            imem_en <= 1'b1;
          end
        end
        FETCH: begin
          state <= WAIT;
        end
        WAIT: begin
          instr       <= imem_rdata;
          instr_valid <= 1'b1;
          state       <= EXEC;
        end
        EXEC: begin
          // Halting instruction still retires and still updates the PC.
          current_pc    <= next_pc_address;
          retired_count <= sat_inc(retired_count);
          if (halt_req) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else if (run) begin
            state   <= FETCH;
            imem_en <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        HALTED: begin
          halted <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed panel scenarios followed by random
// run/step/halt/reset traffic, checked every cycle against a timeline model.
module tb_pc_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        run;
  logic        step;
  logic        halt_req;
  logic [5:0]  next_pc_address;
  logic [15:0] imem_rdata;

  logic [5:0]  current_pc, imem_addr;
  logic        imem_en, instr_valid, halted;
  logic [15:0] instr, retired_count;

  logic [5:0]  pc_s, addr_s;
  logic        en_s, valid_s, halted_s;
  logic [15:0] instr_s;
  logic [3:0]  count_s;

  pc_fetch_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .halt_req(halt_req),
    .next_pc_address(next_pc_address), .imem_rdata(imem_rdata),
    .current_pc(current_pc), .imem_addr(imem_addr), .imem_en(imem_en),
    .instr(instr), .instr_valid(instr_valid), .halted(halted),
    .retired_count(retired_count)
  );

  // Narrow counter copy so saturation is reachable in a short run.
  pc_fetch_sequencer #(.COUNT_WIDTH(4)) dut_sat (
    .clk(clk), .reset(reset), .run(run), .step(step), .halt_req(halt_req),
    .next_pc_address(next_pc_address), .imem_rdata(imem_rdata),
    .current_pc(pc_s), .imem_addr(addr_s), .imem_en(en_s),
    .instr(instr_s), .instr_valid(valid_s), .halted(halted_s),
    .retired_count(count_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory with exactly one cycle of read latency.
  logic [15:0] mem [64];
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem[imem_addr];
  end

  int checks   = 0;
  int failures = 0;

  // Model state: architectural values plus the cycle in which the current
  // instruction was triggered; an instruction occupies the next 3 cycles.
  logic [5:0]  m_pc;
  logic [15:0] m_cnt;
  logic [3:0]  m_cnt4;
  logic [15:0] m_instr;
  bit          m_halted, m_inflight, m_step_prev, inc_mode;
  int          cyc, s_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  // Effect of the coming rising edge given the inputs now applied.
  task automatic model_edge();
    bit rise;
    if (reset) begin
      m_pc = 6'd0; m_cnt = 16'd0; m_cnt4 = 4'd0; m_instr = 16'd0;
      m_halted = 0; m_inflight = 0; m_step_prev = 0;
    end else begin
      rise = step && !m_step_prev;
      m_step_prev = step;
      if (!m_halted) begin
        if (m_inflight && cyc == s_cyc + 2) m_instr = mem[m_pc];
        if (m_inflight && cyc == s_cyc + 3) begin
          m_pc = next_pc_address;
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
          if (m_cnt4 != 4'hF) m_cnt4 = m_cnt4 + 4'd1;
          m_inflight = 0;
          if (halt_req) m_halted = 1;
          else if (run) begin m_inflight = 1; s_cyc = cyc; end
        end else if (!m_inflight && (run || rise)) begin
          m_inflight = 1; s_cyc = cyc;
        end
      end
    end
    cyc++;
  endtask

  task automatic check_outputs();
    logic exp_en, exp_valid;
    exp_en    = m_inflight && (cyc == s_cyc + 1);
    exp_valid = m_inflight && (cyc == s_cyc + 3);
    chk("current_pc", 32'(current_pc), 32'(m_pc));
    chk("imem_addr", 32'(imem_addr), 32'(m_pc));
    chk("imem_en", 32'(imem_en), 32'(exp_en));
    chk("instr_valid", 32'(instr_valid), 32'(exp_valid));
    chk("instr", 32'(instr), 32'(m_instr));
    chk("halted", 32'(halted), 32'(m_halted));
    chk("retired_count", 32'(retired_count), 32'(m_cnt));
    chk("sat_count", 32'(count_s), 32'(m_cnt4));
    chk("sat_pc", 32'(pc_s), 32'(m_pc));
    chk("sat_addr", 32'(addr_s), 32'(m_pc));
    chk("sat_en", 32'(en_s), 32'(exp_en));
    chk("sat_valid", 32'(valid_s), 32'(exp_valid));
    chk("sat_instr", 32'(instr_s), 32'(m_instr));
    chk("sat_halted", 32'(halted_s), 32'(m_halted));
  endtask

  task automatic tick();
    if (inc_mode) next_pc_address = m_pc + 6'd1;
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
    cyc = 0; s_cyc = 0; m_inflight = 0; m_step_prev = 0; m_halted = 0;
    m_pc = 6'd0; m_cnt = 16'd0; m_cnt4 = 4'd0; m_instr = 16'd0;
    inc_mode = 1;
    reset = 1; run = 0; step = 0; halt_req = 0; next_pc_address = 6'd0;

    // Reset state
    ticks(2);
    reset = 0;
    tick();

    // Free run for three instructions, dropping run during the third EXEC
    run = 1;
    ticks(9);
    run = 0;
    ticks(3);
    chk("run3_pc", 32'(current_pc), 32'd3);
    chk("run3_count", 32'(retired_count), 32'd3);

    // Two step edges 10 cycles apart from a fresh reset
    reset = 1; tick(); reset = 0; tick();
    step = 1; tick(); step = 0; ticks(9);
    step = 1; tick(); step = 0; ticks(9);
    chk("step2_pc", 32'(current_pc), 32'd2);
    chk("step2_count", 32'(retired_count), 32'd2);

    // Second edge lands mid-instruction and is dropped
    step = 1; tick(); step = 0; tick(); step = 1; tick(); step = 0; ticks(6);
    chk("step_drop_pc", 32'(current_pc), 32'd3);

    // Branch to 60, then 63, then wrap to 0
    inc_mode = 0;
    next_pc_address = 6'h3C;
    run = 1; tick(); run = 0; ticks(4);
    chk("branch_pc", 32'(current_pc), 32'd60);
    next_pc_address = 6'h3F;
    run = 1; tick(); run = 0; ticks(4);
    chk("pc63", 32'(current_pc), 32'd63);
    next_pc_address = 6'h00;
    run = 1; tick(); run = 0; ticks(4);
    chk("pc_wrap", 32'(current_pc), 32'd0);
    inc_mode = 1;

    // Halt beats run; PC still advances once, then panel inputs are ignored
    halt_req = 1; run = 1;
    ticks(5);
    halt_req = 0;
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_pc", 32'(current_pc), 32'd1);
    for (int i = 0; i < 20; i++) begin
      run = 1'($urandom); step = 1'($urandom);
      tick();
    end
    chk("halt_hold_pc", 32'(current_pc), 32'd1);
    reset = 1; run = 0; step = 0; tick(); reset = 0;
    chk("halt_reset_pc", 32'(current_pc), 32'd0);
    chk("halt_reset_flag", 32'(halted), 32'd0);

    // Reset during WAIT aborts the fetch
    run = 1; tick(); tick();
    reset = 1; run = 0; tick(); reset = 0;
    ticks(5);
    chk("abort_count", 32'(retired_count), 32'd0);

    // Long free run saturates the 4-bit counter copy
    run = 1; ticks(60); run = 0; ticks(4);
    chk("sat4", 32'(count_s), 32'hF);
    chk("count20", 32'(retired_count), 32'd20);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) run = ~run;
      step     = ($urandom_range(0, 3) == 0);
      halt_req = ($urandom_range(0, 39) == 0);
      reset    = m_halted ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 199) == 0);
      inc_mode = 1'($urandom);
      if (!inc_mode) next_pc_address = 6'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
